// File: rtl/uart_mmio_bridge_pkg.sv
// Shared types and constants for the MMIO-to-UART strobe bridge.
// The status register (macro UART_MMIO_BRIDGE_STAT_EN) lives at STAT_OFFSET.
package uart_mmio_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_ISSUE,
    ST_RD_CAP,
    ST_RESP
  } state_t;

  localparam logic [7:0] STAT_OFFSET = 8'hF8;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } tx_entry_t;

  // Width of the byte-lane index inside an XLEN word, never narrower than 1 bit.
  function automatic int lane_width(input int xlen);
    return (xlen / 8 > 1) ? $clog2(xlen / 8) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small posted-write queue of {addr, data} byte entries with a combinational head.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [15:0]              push_data,
  input  logic                     pop,
  output logic [15:0]              pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign pop_data = mem[rd_ptr_reg];

endmodule

// File: rtl/uart_mmio_bridge.sv
// Core MMIO request/response port to UART byte strobes; writes are posted, reads wait
// for the TX queue to drain. Optional status register: UART_MMIO_BRIDGE_STAT_EN.
module uart_mmio_bridge
  import uart_mmio_bridge_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int ADDR_W    = 8,
  parameter int TXQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              uart_wen,
  output logic [7:0]        uart_waddr,
  output logic [7:0]        uart_wdata,
  output logic              uart_ren,
  output logic [7:0]        uart_raddr,
  input  logic [7:0]        uart_rdata
);

  localparam int LANES  = XLEN / 8;
  localparam int LANE_W = lane_width(XLEN);
  localparam int CNT_W  = $clog2(TXQ_DEPTH) + 1;

  state_t              state_reg, state_next;
  logic [7:0]          rd_addr_reg, rd_addr_next;
  logic [LANE_W-1:0]   rd_lane_reg, rd_lane_next;
  logic [XLEN-1:0]     resp_data_reg, resp_data_next;

  logic [7:0]          addr8;
  logic [LANE_W-1:0]   lane;
  logic [7:0]          wbyte [LANES];
  logic [XLEN-1:0]     lane_word;
  logic [XLEN-1:0]     stat_word;
  logic                is_stat;
  logic                accept;
  logic                push;
  logic                drop;

  tx_entry_t           push_entry;
  tx_entry_t           head_entry;
  logic                q_full;
  logic                q_empty;
  logic [CNT_W-1:0]    q_count;

  assign addr8  = 8'(req_addr);
  assign lane   = addr8[LANE_W-1:0];
  assign accept = req_valid && req_ready;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign wbyte[gi] = req_wdata[8*gi +: 8];
      assign lane_word[8*gi +: 8] = (rd_lane_reg == LANE_W'(gi)) ? uart_rdata : 8'h00;
    end
  endgenerate

  assign push_entry = '{addr: addr8, data: wbyte[lane]};

  uart_tx_fifo #(
    .DEPTH (TXQ_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (uart_wen),
    .pop_data  (head_entry),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

`ifdef UART_MMIO_BRIDGE_STAT_EN
  logic [31:0] tx_cnt_reg;
  logic [15:0] drop_cnt_reg;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt_reg   <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (uart_wen && (tx_cnt_reg != '1)) begin
        tx_cnt_reg <= tx_cnt_reg + 32'd1;
      end
      if (drop && (drop_cnt_reg != '1)) begin
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
    end
  end

  assign is_stat   = (addr8 == STAT_OFFSET);
  assign stat_word = XLEN'({drop_cnt_reg, tx_cnt_reg});
`else
  assign is_stat   = 1'b0;
  assign stat_word = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      rd_addr_reg   <= '0;
      rd_lane_reg   <= '0;
      resp_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      rd_addr_reg   <= rd_addr_next;
      rd_lane_reg   <= rd_lane_next;
      resp_data_reg <= resp_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rd_addr_next   = rd_addr_reg;
    rd_lane_next   = rd_lane_reg;
    resp_data_next = resp_data_reg;
    push           = 1'b0;
    drop           = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (req_wen) begin
            resp_data_next = '0;
            state_next     = ST_RESP;
            if (!is_stat) begin
              push = req_wstrb[lane];
              drop = !req_wstrb[lane];
            end
          end else if (is_stat) begin
            resp_data_next = stat_word;
            state_next     = ST_RESP;
          end else begin
            rd_addr_next = addr8;
            rd_lane_next = lane;
            // The queue drains whenever non-empty, so "empty" already implies no pop now.
            state_next   = q_empty ? ST_RD_ISSUE : ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (q_count == '0) begin
          state_next = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: state_next = ST_RD_CAP;
      ST_RD_CAP: begin
        resp_data_next = lane_word;
        state_next     = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Reads only issue once the queue is empty and no pushes occur outside IDLE,
  // so the write and read strobes can never coincide.
  assign req_ready  = (state_reg == ST_IDLE) && !q_full;
  assign resp_valid = (state_reg == ST_RESP);
  assign resp_rdata = resp_valid ? resp_data_reg : '0;
  assign uart_wen   = !q_empty;
  assign uart_waddr = uart_wen ? head_entry.addr : 8'h00;
  assign uart_wdata = uart_wen ? head_entry.data : 8'h00;
  assign uart_ren   = (state_reg == ST_RD_ISSUE);
  assign uart_raddr = uart_ren ? rd_addr_reg : 8'h00;

endmodule
